// File: rtl/vx_gbar_arbiter.sv
// Global barrier arbiter: cores arrive at barrier IDs through a round-robin
// arbiter; a barrier releases (single-cycle broadcast) when the completing
// arrival sees popcount(mask) equal to its participant count.
module vx_gbar_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    localparam int NC_WIDTH    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int NB_WIDTH    = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          dup_err,
    output logic                          busy
);

    logic [NC_WIDTH-1:0]  r_ptr;
    logic [NUM_CORES-1:0] r_mask [NUM_BARRIERS];
    logic                 r_rsp_valid;
    logic [NB_WIDTH-1:0]  r_rsp_id;
    logic                 r_dup_err;
    logic                 r_busy;

    logic                 w_gnt_vld;
    logic [NC_WIDTH-1:0]  w_gnt_idx;
    logic [NB_WIDTH-1:0]  w_acc_id;
    logic [NC_WIDTH-1:0]  w_acc_sz;
    logic [NUM_CORES-1:0] w_row;
    logic [NC_WIDTH:0]    w_cnt;
    logic                 w_rel;
    logic                 w_dup;
    logic                 w_busy_nxt;
    logic [NUM_CORES-1:0] w_mask_nxt [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  w_ptr_nxt;

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        int v_c;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_c       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            v_c = int'(r_ptr) + k;
            if (v_c >= NUM_CORES) v_c = v_c - NUM_CORES;
            if (!w_gnt_vld && req_valid[v_c]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = NC_WIDTH'(v_c);
            end
        end
    end

    // Ready is held low while in reset so nothing is accepted before release
    always_comb begin
        req_ready = '0;
        if (reset_n && w_gnt_vld) req_ready[w_gnt_idx] = 1'b1;
    end

    // Mask update for the accepted arrival: duplicate, completion or accumulate
    always_comb begin
        for (int b = 0; b < NUM_BARRIERS; b++) w_mask_nxt[b] = r_mask[b];
        w_rel    = 1'b0;
        w_dup    = 1'b0;
        w_acc_id = req_id[w_gnt_idx*NB_WIDTH +: NB_WIDTH];
        w_acc_sz = req_size_m1[w_gnt_idx*NC_WIDTH +: NC_WIDTH];
        w_row    = r_mask[w_acc_id];
        w_row[w_gnt_idx] = 1'b1;
        w_cnt    = '0;
        for (int j = 0; j < NUM_CORES; j++) w_cnt = w_cnt + (NC_WIDTH+1)'(w_row[j]);
        if (w_gnt_vld) begin
            if (r_mask[w_acc_id][w_gnt_idx]) begin
                w_dup = 1'b1;
            end else if (w_cnt == ({1'b0, w_acc_sz} + (NC_WIDTH+1)'(1))) begin
                w_mask_nxt[w_acc_id] = '0;
                w_rel                = 1'b1;
            end else begin
                w_mask_nxt[w_acc_id] = w_row;
            end
        end
        w_busy_nxt = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) w_busy_nxt = w_busy_nxt | (|w_mask_nxt[b]);
    end

    // Pointer moves past the granted core, wrapping at NUM_CORES
    always_comb begin
        if (int'(w_gnt_idx) == NUM_CORES - 1) w_ptr_nxt = '0;
        else                                  w_ptr_nxt = w_gnt_idx + NC_WIDTH'(1);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) r_mask[b] <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_dup_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) r_mask[b] <= w_mask_nxt[b];
            if (w_gnt_vld) r_ptr <= w_ptr_nxt;
            r_rsp_valid <= w_rel;
            if (w_rel) r_rsp_id <= w_acc_id;
            if (w_dup) r_dup_err <= 1'b1;
            r_busy <= w_busy_nxt;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign dup_err   = r_dup_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vx_gbar_arbiter.sv
// Bench for vx_gbar_arbiter: directed barrier scenarios with literal
// expectations, then randomized traffic checked against a set-based model.
module tb_vx_gbar_arbiter;

    localparam int N   = 4;
    localparam int NB  = 8;
    localparam int NBW = 3;
    localparam int NCW = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*NBW-1:0] req_id;
    logic [N*NCW-1:0] req_size_m1;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [NBW-1:0]   rsp_id;
    logic             dup_err;
    logic             busy;

    vx_gbar_arbiter #(.NUM_CORES(N), .NUM_BARRIERS(NB)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_id(req_id),
        .req_size_m1(req_size_m1), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .dup_err(dup_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: arrival set per barrier, pointer, registered outputs
    logic [N-1:0] m_mask [NB];
    int           m_ptr;
    bit           m_rsp_v;
    int           m_rsp_id;
    bit           m_dup;
    bit           m_busy;
    int           last_grant;
    logic [N-1:0] seen_ready;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_mask[b] = '0;
        m_ptr = 0; m_rsp_v = 0; m_rsp_id = 0; m_dup = 0; m_busy = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(int g);
        int b, s;
        m_rsp_v = 0;
        if (g >= 0) begin
            b = int'(req_id[g*NBW +: NBW]);
            s = int'(req_size_m1[g*NCW +: NCW]);
            if (m_mask[b][g]) m_dup = 1;
            else if ($countones(m_mask[b] | (N'(1) << g)) == s + 1) begin
                m_mask[b] = '0; m_rsp_v = 1; m_rsp_id = b;
            end else m_mask[b][g] = 1'b1;
            m_ptr = (g + 1) % N;
        end
        m_busy = 0;
        for (int i = 0; i < NB; i++) if (m_mask[i] != 0) m_busy = 1;
    endtask

    task automatic set_req(int c, bit v, int id, int sz);
        req_valid[c] = v;
        req_id[c*NBW +: NBW] = NBW'(id);
        req_size_m1[c*NCW +: NCW] = NCW'(sz);
    endtask

    // one clock: compare away from the edge, advance model at the edge
    task automatic cycle();
        int g;
        logic [N-1:0] e;
        #1;
        g = model_grant();
        e = '0;
        if (reset_n && g >= 0) e[g] = 1'b1;
        seen_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(e));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v) chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
        chk("dup_err", 32'(dup_err), 32'(m_dup));
        chk("busy", 32'(busy), 32'(m_busy));
        @(posedge clk);
        if (reset_n) model_edge(g);
        last_grant = reset_n ? g : -1;
        @(negedge clk);
    endtask

    task automatic one(int c, int id, int sz);
        set_req(c, 1, id, sz);
        cycle();
        set_req(c, 0, 0, 0);
    endtask

    // asynchronous reset asserted between edges
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_dup_err", 32'(dup_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        model_reset();
        last_grant = -1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_id = '0; req_size_m1 = '0;
        model_reset();
        last_grant = -1;
        #1;
        chk("init_rsp_id", 32'(rsp_id), 32'h0);
        chk("init_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // basic release at ID 2
        one(0, 2, 3); one(1, 2, 3); one(2, 2, 3);
        chk("basic_busy_pending", 32'(busy), 32'h1);
        one(3, 2, 3);
        chk("basic_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("basic_rsp_id", 32'(rsp_id), 32'h2);
        chk("basic_busy_clear", 32'(busy), 32'h0);

        // fairness: all four held, pointer at 0
        for (int c = 0; c < N; c++) set_req(c, 1, 1, 3);
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("fair_grant", 32'(seen_ready), 32'(1 << k));
            if (last_grant >= 0) set_req(last_grant, 0, 0, 0);
        end
        chk("fair_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("fair_rsp_id", 32'(rsp_id), 32'h1);
        cycle();
        chk("fair_single_pulse", 32'(rsp_valid), 32'h0);

        // duplicate arrival
        one(1, 0, 1);
        chk("dup_before", 32'(dup_err), 32'h0);
        one(1, 0, 1);
        chk("dup_set", 32'(dup_err), 32'h1);
        chk("dup_no_release", 32'(rsp_valid), 32'h0);
        one(2, 0, 1);
        chk("dup_release", 32'(rsp_valid), 32'h1);
        chk("dup_release_id", 32'(rsp_id), 32'h0);

        // concurrent IDs 3 and 5
        one(0, 3, 1); one(1, 5, 2);
        one(2, 3, 1);
        chk("conc_rel3", 32'(rsp_valid), 32'h1);
        chk("conc_rel3_id", 32'(rsp_id), 32'h3);
        one(3, 5, 2);
        chk("conc_no_rel5_early", 32'(rsp_valid), 32'h0);
        one(0, 5, 2);
        chk("conc_rel5", 32'(rsp_valid), 32'h1);
        chk("conc_rel5_id", 32'(rsp_id), 32'h5);

        // degenerate size and immediate reuse of ID 7
        one(2, 7, 0);
        chk("deg_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("deg_rsp_id", 32'(rsp_id), 32'h7);
        one(1, 7, 1);
        chk("reuse_no_release", 32'(rsp_valid), 32'h0);
        chk("reuse_busy", 32'(busy), 32'h1);
        one(3, 7, 1);
        chk("reuse_release", 32'(rsp_valid), 32'h1);
        chk("reuse_release_id", 32'(rsp_id), 32'h7);

        // reset with mask[4]=0111 and a completing request waiting
        one(0, 4, 3); one(1, 4, 3); one(2, 4, 3);
        chk("rst_pending_busy", 32'(busy), 32'h1);
        set_req(3, 1, 4, 3);
        do_reset();
        cycle();
        set_req(3, 0, 0, 0);
        chk("post_rst_no_release", 32'(rsp_valid), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int c = 0; c < N; c++)
                    if (!req_valid[c] && $urandom_range(0, 1) == 1)
                        set_req(c, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                cycle();
                if (last_grant >= 0) set_req(last_grant, 0, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_gbar_arbiter.md
VX_GBAR_ARBITER -- requirements
Module: VX_gbar_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of requesting cores (2..32).
REQ-002 SHALL have parameter NUM_BARRIERS, default 8, number of global barrier IDs (power of 2, 2..32).
REQ-003 SHALL derive NC_WIDTH = max(1, clog2(NUM_CORES)) and NB_WIDTH = max(1, clog2(NUM_BARRIERS)) internally, not as overridable parameters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  NUM_CORES  per-core barrier arrival request.
REQ-007 SHALL have port req_id  input  NUM_CORES x NB_WIDTH  per-core barrier ID.
REQ-008 SHALL have port req_size_m1  input  NUM_CORES x NC_WIDTH  per-core participant count minus one.
REQ-009 SHALL have port req_ready  output  NUM_CORES  per-core accept (one-hot or zero).
REQ-010 SHALL have port rsp_valid  output  1  barrier release broadcast, single-cycle pulse.
REQ-011 SHALL have port rsp_id  output  NB_WIDTH  ID of the released barrier.
REQ-012 SHALL have port dup_err  output  1  sticky flag: duplicate arrival detected.
REQ-013 SHALL have port busy  output  1  high while any barrier has a pending arrival.

Function
REQ-014 SHALL keep an arrival mask per barrier ID: NUM_BARRIERS x NUM_CORES bits, one bit per core.
REQ-015 SHALL grant at most one request per cycle through a round-robin arbiter; req_ready[i] is combinational from req_valid and the priority pointer.
REQ-016 SHALL move the priority pointer to (granted index + 1) mod NUM_CORES after each accept, and leave it unchanged in cycles without an accept.
REQ-017 SHALL define accept on core i as req_valid[i] && req_ready[i]; a requester holds valid, id and size_m1 stable until accepted.
REQ-018 SHALL, on accept from core i for ID b, set mask[b][i]; if popcount(mask[b] with bit i set) == req_size_m1[i] + 1, it SHALL clear mask[b] to zero instead of setting the bit and schedule a release.
REQ-019 SHALL use only the size_m1 of the completing (accepted) request; size fields of earlier arrivals are not stored.
REQ-020 SHALL compute the popcount in NC_WIDTH+1 bits and compare it against zero-extended size_m1+1 with no overflow.
REQ-021 SHALL drive rsp_valid=1 and rsp_id=b exactly one cycle after the completing accept, for one cycle (registered output, latency 1).
REQ-022 SHALL, for size_m1 == 0, release on the single arrival with rsp_valid one cycle later.
REQ-023 SHALL, if core i is accepted for ID b while mask[b][i] is already 1, leave mask[b] unchanged, produce no release, and set dup_err; dup_err stays 1 until reset.
REQ-024 SHALL let a barrier ID be reused immediately: an arrival for b in the cycle after its release starts a fresh mask.
REQ-025 SHALL let different barrier IDs accumulate independently and concurrently.
REQ-026 SHALL accept a request in the same cycle that rsp_valid is high, including one for the same ID just released.
REQ-027 SHALL drive busy = OR of all mask bits, registered (reflects state after the previous edge).

Reset
REQ-028 SHALL, while reset_n=0, immediately clear all masks, set pointer=0, rsp_valid=0, rsp_id=0, dup_err=0, busy=0.
REQ-029 SHALL, while reset_n=0, keep req_ready all zero.
REQ-030 SHALL, on reset mid-operation, discard all pending arrivals; a release scheduled for the next edge is suppressed.
REQ-031 SHALL release reset synchronously to clk; the first accept occurs no earlier than the first edge with reset_n=1.

Verification
REQ-032 SHALL cover basic release: NUM_CORES=4; cores 0,1,2,3 arrive at ID 2 with size_m1=3 on successive cycles -> rsp_valid=1, rsp_id=2 in the cycle after core 3 is accepted; busy then drops to 0.
REQ-033 SHALL cover arbitration fairness: all four cores hold req_valid with ID 1, size_m1=3, starting from pointer=0 -> grants in order 0,1,2,3, one per cycle, then a single release of ID 1.
REQ-034 SHALL cover duplicate arrival: core 1 arrives twice at ID 0 (size_m1=1), then core 2 arrives -> dup_err=1 after the second arrival, and the release fires after core 2 is accepted.
REQ-035 SHALL cover concurrent IDs: interleaved arrivals to ID 3 (size_m1=1) and ID 5 (size_m1=2) -> two separate single-cycle pulses with correct rsp_id and no cross-contamination.
REQ-036 SHALL cover degenerate and reuse cases: size_m1=0 from core 2 at ID 7 -> pulse with rsp_id=7 one cycle later; a new arrival at ID 7 in the pulse cycle starts a fresh mask.
REQ-037 SHALL cover reset mid-operation: assert reset_n=0 with mask[4]=0b0111 pending -> all outputs are zero immediately, and after reset the first arrival at ID 4 does not release.
